// File: rtl/data_types_pkg.sv
// rtl/data_types_pkg.sv - shared data types for the instruction front end
package data_types_pkg;

    typedef logic [31:0] word32_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } fetch_state_e;

    localparam word32_t FETCH_PC_STEP = 32'd4;

    function automatic word32_t word_align(input word32_t addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage feeding the instruction fifo
module fetch_unit
    import data_types_pkg::*;
#(
    parameter word32_t RESET_PC = 32'h0000_0000,
    parameter word32_t PC_STEP  = FETCH_PC_STEP
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        halt_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    input  logic        req_ready_i,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_data_i,
    input  logic        rsp_err_i,
    input  logic        fifo_full_i,
    output logic        fifo_write_o,
    output logic [31:0] fifo_wdata_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    fetch_state_e state;
    word32_t      pc;
    word32_t      req_addr;
    logic         req_valid;
    logic         fault;
    logic         kill;
    logic         rsp_here;
    logic         rsp_keep;

    // A response only counts in WAIT; kill or a same-cycle redirect makes it stale.
    assign rsp_here = (state == FETCH_WAIT) && rsp_valid_i;
    assign rsp_keep = rsp_here && !kill && !redirect_i;

    assign fifo_write_o = rsp_keep && !rsp_err_i;
    assign fifo_wdata_o = fifo_write_o ? rsp_data_i : 32'h0;
    assign req_valid_o  = req_valid;
    assign req_addr_o   = req_addr;
    assign pc_o         = pc;
    assign fault_o      = fault;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= FETCH_IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            req_valid <= 1'b0;
            fault     <= 1'b0;
            kill      <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (!halt_i && !fifo_full_i && !redirect_i && !fault) begin
                        state     <= FETCH_REQ;
                        req_valid <= 1'b1;
                        req_addr  <= pc;
                    end
                end
                FETCH_REQ: begin
                    if (req_ready_i) begin
                        state     <= FETCH_WAIT;
                        req_valid <= 1'b0;
                    end
                end
                FETCH_WAIT: begin
                    if (rsp_valid_i) begin
                        state <= FETCH_IDLE;
                        kill  <= 1'b0;
                        if (rsp_keep) begin
                            if (rsp_err_i) begin
                                fault <= 1'b1;
                            end else begin
                                pc <= pc + PC_STEP;
                            end
                        end
                    end
                end
                default: begin
                    state     <= FETCH_IDLE;
                    req_valid <= 1'b0;
                    kill      <= 1'b0;
                end
            endcase

            // The request in flight cannot be retracted, so its response is marked stale instead.
            if (redirect_i) begin
                pc    <= word_align(redirect_pc_i);
                fault <= 1'b0;
                if ((state == FETCH_REQ) || ((state == FETCH_WAIT) && !rsp_valid_i)) begin
                    kill <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        halt_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        rsp_err_i;
    logic        fifo_full_i;
    logic        fifo_write_o;
    logic [31:0] fifo_wdata_o;
    logic [31:0] pc_o;
    logic        fault_o;

    int vectors = 0;
    int errors  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .halt_i        (halt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .req_valid_o   (req_valid_o),
        .req_addr_o    (req_addr_o),
        .req_ready_i   (req_ready_i),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_data_i    (rsp_data_i),
        .rsp_err_i     (rsp_err_i),
        .fifo_full_i   (fifo_full_i),
        .fifo_write_o  (fifo_write_o),
        .fifo_wdata_o  (fifo_wdata_o),
        .pc_o          (pc_o),
        .fault_o       (fault_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // From IDLE: request, accept, one-cycle-latency response written to the fifo.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        tick();
        chk("req_valid_issue", {31'b0, req_valid_o}, 32'd1);
        chk("req_addr_issue", req_addr_o, addr);
        tick();
        chk("req_valid_after_accept", {31'b0, req_valid_o}, 32'd0);
        rsp_valid_i = 1'b1;
        rsp_data_i  = data;
        #1;
        chk("fifo_write_on_rsp", {31'b0, fifo_write_o}, 32'd1);
        chk("fifo_wdata", fifo_wdata_o, data);
        chk("pc_before_step", pc_o, addr);
        tick();
        rsp_valid_i = 1'b0;
        #1;
        chk("fifo_write_single", {31'b0, fifo_write_o}, 32'd0);
        chk("pc_after_step", pc_o, addr + 32'd4);
    endtask

    task automatic redir(input logic [31:0] target);
        redirect_i    = 1'b1;
        redirect_pc_i = target;
        tick();
        redirect_i = 1'b0;
    endtask

    initial begin
        reset_ni      = 1'b0;
        halt_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        req_ready_i   = 1'b1;
        rsp_valid_i   = 1'b0;
        rsp_data_i    = 32'h0;
        rsp_err_i     = 1'b0;
        fifo_full_i   = 1'b0;
        tick();
        tick();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_req_addr", req_addr_o, 32'h0);
        chk("rst_req_valid", {31'b0, req_valid_o}, 32'd0);
        chk("rst_fifo_write", {31'b0, fifo_write_o}, 32'd0);
        chk("rst_fifo_wdata", fifo_wdata_o, 32'h0);
        chk("rst_fault", {31'b0, fault_o}, 32'd0);
        reset_ni = 1'b1;

        // Back-to-back fetches with an always-ready memory.
        fetch_one(32'h0, 32'h100);
        fetch_one(32'h4, 32'h104);
        fetch_one(32'h8, 32'h108);

        // Fifo full stalls fetch at the current pc.
        fifo_full_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_no_req", {31'b0, req_valid_o}, 32'd0);
            chk("full_pc_hold", pc_o, 32'hC);
        end
        fifo_full_i = 1'b0;
        fetch_one(32'hC, 32'h10C);

        // Memory not ready: request held stable.
        req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_req_valid", {31'b0, req_valid_o}, 32'd1);
            chk("stall_req_addr", req_addr_o, 32'h10);
        end
        req_ready_i = 1'b1;
        tick();
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'h110;
        #1;
        chk("stall_rsp_write", {31'b0, fifo_write_o}, 32'd1);
        chk("stall_rsp_data", fifo_wdata_o, 32'h110);
        tick();
        rsp_valid_i = 1'b0;
        chk("stall_pc", pc_o, 32'h14);

        // Redirect in IDLE issues no request that cycle.
        redir(32'h8);
        chk("idle_redir_no_req", {31'b0, req_valid_o}, 32'd0);
        chk("idle_redir_pc", pc_o, 32'h8);

        // Redirect while waiting for 0x8: late response is dropped.
        tick();
        chk("wait_req_addr", req_addr_o, 32'h8);
        tick();
        redir(32'h203);
        chk("wait_redir_pc", pc_o, 32'h200);
        tick();
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'hDEAD_BEEF;
        #1;
        chk("killed_rsp_no_write", {31'b0, fifo_write_o}, 32'd0);
        tick();
        rsp_valid_i = 1'b0;
        chk("killed_rsp_pc", pc_o, 32'h200);
        fetch_one(32'h200, 32'h300);

        // Redirect coincident with a response.
        tick();
        tick();
        rsp_valid_i   = 1'b1;
        rsp_data_i    = 32'h1234_5678;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        #1;
        chk("coincident_no_write", {31'b0, fifo_write_o}, 32'd0);
        tick();
        rsp_valid_i = 1'b0;
        redirect_i  = 1'b0;
        chk("coincident_pc", pc_o, 32'h80);
        fetch_one(32'h80, 32'h180);

        // Bus error on fetch of 0xC sets a sticky fault.
        redir(32'hC);
        tick();
        tick();
        rsp_valid_i = 1'b1;
        rsp_err_i   = 1'b1;
        rsp_data_i  = 32'hBAD0_BAD0;
        #1;
        chk("err_no_write", {31'b0, fifo_write_o}, 32'd0);
        tick();
        rsp_valid_i = 1'b0;
        rsp_err_i   = 1'b0;
        chk("err_fault_set", {31'b0, fault_o}, 32'd1);
        chk("err_pc_hold", pc_o, 32'hC);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fault_no_req", {31'b0, req_valid_o}, 32'd0);
        end
        redir(32'h40);
        chk("fault_cleared", {31'b0, fault_o}, 32'd0);
        chk("fault_redir_pc", pc_o, 32'h40);
        chk("fault_redir_no_req", {31'b0, req_valid_o}, 32'd0);
        fetch_one(32'h40, 32'h140);

        // Reset mid-transaction, then a stray response in IDLE.
        tick();
        tick();
        reset_ni = 1'b0;
        #1;
        chk("midrst_req_valid", {31'b0, req_valid_o}, 32'd0);
        chk("midrst_pc", pc_o, 32'h0);
        chk("midrst_req_addr", req_addr_o, 32'h0);
        tick();
        reset_ni    = 1'b1;
        halt_i      = 1'b1;
        rsp_valid_i = 1'b1;
        rsp_data_i  = 32'h5555_AAAA;
        #1;
        chk("stray_rsp_no_write", {31'b0, fifo_write_o}, 32'd0);
        tick();
        rsp_valid_i = 1'b0;
        chk("stray_rsp_pc", pc_o, 32'h0);
        chk("halt_no_req", {31'b0, req_valid_o}, 32'd0);
        halt_i = 1'b0;

        // pc wraps modulo 2^32.
        redir(32'hFFFF_FFFE);
        chk("wrap_redir_pc", pc_o, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
